// File: rtl/fft4_input_loader.sv
`default_nettype none
// ============================================================================
// fft4_input_loader: loads 4-sample complex frames bit-reversed into a
// ping-pong buffer and serves radix-2 first-stage butterfly operand sets.
// Revision: 1.0
// ============================================================================
module fft4_input_loader #(
  parameter int WIDTH = 32,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_w,
  output logic             out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  // W0 = 1 + j0 in Q1.(HALF-1): largest positive real, zero imaginary
  localparam logic [WIDTH-1:0] W_ONE = {1'b0, {(HALF-1){1'b1}}, {HALF{1'b0}}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

  logic [WIDTH-1:0] mem [2][4];
  logic             wbank;
  logic [1:0]       wcnt;
  logic             rbank;
  logic             rcnt;
  logic [1:0]       full;
  logic             in_accept;
  logic             out_accept;

  assign in_ready   = ~full[wbank];
  assign out_valid  = full[rbank];
  assign in_accept  = in_valid & in_ready;
  assign out_accept = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank <= 1'b0;
      wcnt  <= 2'd0;
    end else if (in_accept) begin
      wcnt <= wcnt + 2'd1;
      if (wcnt == 2'd3) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbank <= 1'b0;
      rcnt  <= 1'b0;
    end else if (out_accept) begin
      rcnt <= ~rcnt;
      if (rcnt) rbank <= ~rbank;
    end
  end

  // Bit-reversed write address puts x0,x2 in slots 0,1 and x1,x3 in slots 2,3
  always_ff @(posedge clk) begin
    if (in_accept) mem[wbank][{wcnt[0], wcnt[1]}] <= in_data;
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      bank_state_t state;
      bank_state_t state_nxt;
      logic        set_full;
      logic        clr_full;

      assign set_full = in_accept && (wcnt == 2'd3) && (wbank == 1'(b));
      assign clr_full = out_accept && rcnt && (rbank == 1'(b));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
      end

      always_comb begin
        state_nxt = state;
        case (state)
          EMPTY:   if (set_full) state_nxt = FULL;
          FULL:    if (clr_full) state_nxt = EMPTY;
          default: state_nxt = EMPTY;
        endcase
      end

      assign full[b] = (state == FULL);
    end
  endgenerate

  always_comb begin
    out_a   = '0;
    out_b   = '0;
    out_w   = '0;
    out_idx = rcnt;
    if (out_valid) begin
      out_a = mem[rbank][{rcnt, 1'b0}];
      out_b = mem[rbank][{rcnt, 1'b1}];
      out_w = W_ONE;
    end
  end

endmodule
`default_nettype wire
